// File: rtl/pmem_ctrl_pkg.sv
// Shared definitions for the program/parameter memory controller: command opcodes
// and controller FSM states.
package pmem_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_FILL  = 2'd2,
        OP_DUMP  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_FILL    = 3'd3,
        ST_DUMP_RD = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/pmem_ctrl_if.sv
// Command, response and memory-pin bundle of the pmem controller; the controller
// uses the slave view, the host/memory side uses the master view.
interface pmem_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_dout,
        output cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
               mem_addr, mem_we, mem_din, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_dout,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
               mem_addr, mem_we, mem_din, busy
    );
endinterface

// File: rtl/pmem_ctrl_addr_seq.sv
// Word-address sequencer shared by FILL and DUMP: clears to 0, steps by one and
// saturates at DEPTH-1, with a registered flag marking the final address.
module pmem_ctrl_addr_seq #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              last
);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] cnt_r;
    logic              last_r;

    // Counter and final-address flag; increment is ignored once the last word is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            last_r <= (LAST_CNT == '0);
        end else if (clr) begin
            cnt_r  <= '0;
            last_r <= (LAST_CNT == '0);
        end else if (inc && !last_r) begin
            cnt_r  <= cnt_r + ADDR_W'(1);
            last_r <= ((cnt_r + ADDR_W'(1)) == LAST_CNT);
        end
    end

    assign cnt  = cnt_r;
    assign last = last_r;
endmodule

// File: rtl/pmem_ctrl.sv
// Command-driven initiator for the program/parameter memory (WRITE/READ/FILL/DUMP).
// Define PMEM_CTRL_CHECKSUM_EN to append an XOR checksum beat to every DUMP.
module pmem_ctrl
    import pmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic         clk,
    input  logic         rst,
    pmem_ctrl_if.slave   bus
);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e            state_r;
    op_e               op_r;
    logic [DATA_W-1:0] data_r;
    logic              err_r;
    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_last_r;
    logic              rsp_err_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic [DATA_W-1:0] mem_din_r;
    logic              busy_r;
`ifdef PMEM_CTRL_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;
`endif

    logic              accept_s;
    logic              rsp_hs_s;
    logic              in_range_s;
    logic              seq_clr_s;
    logic              seq_inc_s;
    logic [ADDR_W-1:0] seq_cnt_s;
    logic              seq_last_s;

    assign accept_s   = bus.cmd_valid & cmd_ready_r;
    assign rsp_hs_s   = rsp_valid_r & bus.rsp_ready;
    assign in_range_s = ({1'b0, bus.cmd_addr} < DEPTH_EXT);

    pmem_ctrl_addr_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_seq (
        .clk  (clk),
        .rst  (rst),
        .clr  (seq_clr_s),
        .inc  (seq_inc_s),
        .cnt  (seq_cnt_s),
        .last (seq_last_s)
    );

    // Address sequencer control: restart on accept, step per FILL write or per DUMP handshake.
    always_comb begin
        seq_clr_s = 1'b0;
        seq_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: seq_clr_s = accept_s;
            ST_FILL: seq_inc_s = ~seq_last_s;
            ST_RSP:  seq_inc_s = rsp_hs_s & ~rsp_last_r & (op_r == OP_DUMP) & ~seq_last_s;
            default: begin
                seq_clr_s = 1'b0;
                seq_inc_s = 1'b0;
            end
        endcase
    end

    // Controller FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_WRITE;
            data_r      <= '0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_last_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_din_r   <= '0;
            busy_r      <= 1'b0;
`ifdef PMEM_CTRL_CHECKSUM_EN
            csum_r      <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        op_r        <= op_e'(bus.cmd_op);
                        data_r      <= bus.cmd_data;
                        mem_din_r   <= bus.cmd_data;
                        case (op_e'(bus.cmd_op))
                            OP_WRITE: begin
                                state_r    <= ST_WRITE;
                                mem_addr_r <= bus.cmd_addr;
                                mem_we_r   <= in_range_s;
                                err_r      <= ~in_range_s;
                            end
                            OP_READ: begin
                                state_r    <= ST_READ;
                                mem_addr_r <= bus.cmd_addr;
                                err_r      <= ~in_range_s;
                            end
                            OP_FILL: begin
                                state_r    <= ST_FILL;
                                mem_addr_r <= '0;
                                mem_we_r   <= 1'b1;
                                err_r      <= 1'b0;
                            end
                            OP_DUMP: begin
                                state_r    <= ST_DUMP_RD;
                                mem_addr_r <= '0;
                                err_r      <= 1'b0;
`ifdef PMEM_CTRL_CHECKSUM_EN
                                csum_r     <= '0;
`endif
                            end
                            default: begin
                                state_r     <= ST_IDLE;
                                cmd_ready_r <= 1'b1;
                                busy_r      <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    mem_we_r    <= 1'b0;
                    state_r     <= ST_RSP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= data_r;
                    rsp_last_r  <= 1'b1;
                    rsp_err_r   <= err_r;
                end
                ST_READ: begin
                    state_r     <= ST_RSP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= err_r ? '0 : bus.mem_dout;
                    rsp_last_r  <= 1'b1;
                    rsp_err_r   <= err_r;
                end
                ST_FILL: begin
                    if (seq_last_s) begin
                        mem_we_r    <= 1'b0;
                        state_r     <= ST_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= data_r;
                        rsp_last_r  <= 1'b1;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        mem_addr_r  <= seq_cnt_s + ADDR_W'(1);
                    end
                end
                ST_DUMP_RD: begin
                    state_r     <= ST_RSP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= bus.mem_dout;
                    rsp_err_r   <= 1'b0;
`ifdef PMEM_CTRL_CHECKSUM_EN
                    rsp_last_r  <= 1'b0;
                    csum_r      <= csum_r ^ bus.mem_dout;
`else
                    rsp_last_r  <= seq_last_s;
`endif
                end
                ST_RSP: begin
                    if (rsp_hs_s) begin
                        if (rsp_last_r) begin
                            state_r     <= ST_IDLE;
                            rsp_valid_r <= 1'b0;
                            rsp_last_r  <= 1'b0;
                            rsp_err_r   <= 1'b0;
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
`ifdef PMEM_CTRL_CHECKSUM_EN
                        end else if (seq_last_s) begin
                            // Last data word consumed: present the checksum beat next.
                            rsp_data_r  <= csum_r;
                            rsp_last_r  <= 1'b1;
`endif
                        end else begin
                            state_r     <= ST_DUMP_RD;
                            rsp_valid_r <= 1'b0;
                            mem_addr_r  <= seq_cnt_s + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    mem_we_r    <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_last  = rsp_last_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_din   = mem_din_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_pmem_ctrl.sv
// Self-checking bench for pmem_ctrl: models the memory array, keeps a reference copy
// of its contents and checks every response against it.
module tb_pmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    pmem_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bif ();

    pmem_ctrl #(.ADDR_W(4), .DATA_W(4), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // Memory under control: combinational read, write on the clock edge.
    logic [3:0] mem_arr [16];
    assign bif.mem_dout = mem_arr[bif.mem_addr];
    always @(posedge clk) if (bif.mem_we === 1'b1) mem_arr[bif.mem_addr] <= bif.mem_din;

    // Write-enable monitor: records address and cycle of every write cycle.
    int         cyc = 0;
    logic [3:0] we_addr_q [$];
    int         we_cyc_q [$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bif.mem_we === 1'b1) begin
            we_addr_q.push_back(bif.mem_addr);
            we_cyc_q.push_back(cyc);
        end
    end

    logic [3:0] ref_mem [8];

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] data);
        int n = 0;
        while (bif.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL cmd_ready_timeout got=%b want=1", bif.cmd_ready);
        end
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_addr  = addr;
        bif.cmd_data  = data;
        @(negedge clk);
        bif.cmd_valid = 1'b0;
    endtask

    task automatic get_beat(input bit rand_ready, output logic [3:0] d, output logic l, output logic e);
        int         n = 0;
        bit         seen = 1'b0;
        bit         done = 1'b0;
        logic [5:0] held = '0;
        logic [5:0] cur;
        d = 'x; l = 'x; e = 'x;
        while (!done && n < 300) begin
            if (bif.rsp_valid === 1'b1) begin
                cur = {bif.rsp_data, bif.rsp_last, bif.rsp_err};
                if (seen) begin
                    total++;
                    if (cur !== held) begin
                        bad++;
                        $display("FAIL beat_stable got=%h want=%h", cur, held);
                    end
                end
                held = cur; seen = 1'b1;
                d = bif.rsp_data; l = bif.rsp_last; e = bif.rsp_err;
                bif.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bif.rsp_ready) done = 1'b1;
            end
            @(negedge clk);
            bif.rsp_ready = 1'b0;
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL rsp_timeout got=no_beat want=beat");
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0 || bif.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle got rdy=%b busy=%b vld=%b want 1 0 0", tag, bif.cmd_ready, bif.busy, bif.rsp_valid);
        end
    endtask

    task automatic run_dump(input bit rand_ready);
        logic [3:0] d;
        logic       l, e;
        logic [3:0] x = 4'h0;
        bit         exp_last;
        do_cmd(2'd3, 4'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            get_beat(rand_ready, d, l, e);
`ifdef PMEM_CTRL_CHECKSUM_EN
            exp_last = 1'b0;
`else
            exp_last = (i == 7);
`endif
            x = x ^ ref_mem[i];
            total++;
            if (d !== ref_mem[i] || l !== exp_last || e !== 1'b0) begin
                bad++;
                $display("FAIL dump_beat%0d got d=%h l=%b e=%b want d=%h l=%b e=0", i, d, l, e, ref_mem[i], exp_last);
            end
        end
`ifdef PMEM_CTRL_CHECKSUM_EN
        get_beat(rand_ready, d, l, e);
        total++;
        if (d !== x || l !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL dump_csum got d=%h l=%b e=%b want d=%h l=1 e=0", d, l, e, x);
        end
`endif
        check_idle("dump");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bif.cmd_ready !== 1'b1 || bif.rsp_valid !== 1'b0 || bif.mem_we !== 1'b0 || bif.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b we=%b busy=%b want 1 0 0 0", bif.cmd_ready, bif.rsp_valid, bif.mem_we, bif.busy);
        end
        total++;
        if (bif.rsp_last !== 1'b0 || bif.rsp_err !== 1'b0 || bif.rsp_data !== 4'h0 || bif.mem_addr !== 4'h0 || bif.mem_din !== 4'h0) begin
            bad++;
            $display("FAIL reset_data got last=%b err=%b d=%h a=%h din=%h want all 0", bif.rsp_last, bif.rsp_err, bif.rsp_data, bif.mem_addr, bif.mem_din);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] d;
        logic       l, e;
        int         q0 = we_addr_q.size();
        do_cmd(2'd0, 4'h3, 4'hA);
        total++;
        if (bif.mem_we !== 1'b1 || bif.mem_addr !== 4'h3 || bif.mem_din !== 4'hA || bif.rsp_valid !== 1'b0 || bif.busy !== 1'b1) begin
            bad++;
            $display("FAIL write_cycle got we=%b a=%h din=%h vld=%b busy=%b want 1 3 a 0 1", bif.mem_we, bif.mem_addr, bif.mem_din, bif.rsp_valid, bif.busy);
        end
        @(negedge clk);
        total++;
        if (bif.rsp_valid !== 1'b1 || bif.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL write_latency got vld=%b we=%b want 1 0", bif.rsp_valid, bif.mem_we);
        end
        get_beat(1'b0, d, l, e);
        ref_mem[3] = 4'hA;
        total++;
        if (d !== 4'hA || l !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL write_rsp got d=%h l=%b e=%b want a 1 0", d, l, e);
        end
        check_idle("write");
        total++;
        if (we_addr_q.size() - q0 != 1) begin
            bad++;
            $display("FAIL write_we_pulses got=%0d want=1", we_addr_q.size() - q0);
        end
        do_cmd(2'd1, 4'h3, 4'h0);
        get_beat(1'b0, d, l, e);
        total++;
        if (d !== 4'hA || l !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL read_back got d=%h l=%b e=%b want a 1 0", d, l, e);
        end
    endtask

    task automatic test_write_oob();
        logic [3:0] d;
        logic       l, e;
        int         q0 = we_addr_q.size();
        do_cmd(2'd0, 4'h9, 4'h6);
        get_beat(1'b0, d, l, e);
        total++;
        if (l !== 1'b1 || e !== 1'b1 || we_addr_q.size() != q0) begin
            bad++;
            $display("FAIL write_oob got l=%b e=%b we=%0d want 1 1 0", l, e, we_addr_q.size() - q0);
        end
        do_cmd(2'd1, 4'hC, 4'h0);
        get_beat(1'b0, d, l, e);
        total++;
        if (d !== 4'h0 || l !== 1'b1 || e !== 1'b1) begin
            bad++;
            $display("FAIL read_oob got d=%h l=%b e=%b want 0 1 1", d, l, e);
        end
    endtask

    task automatic test_fill_dump();
        logic [3:0] d;
        logic       l, e;
        int         q0 = we_addr_q.size();
        do_cmd(2'd2, 4'h0, 4'h5);
        get_beat(1'b0, d, l, e);
        for (int i = 0; i < 8; i++) ref_mem[i] = 4'h5;
        total++;
        if (d !== 4'h5 || l !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL fill_rsp got d=%h l=%b e=%b want 5 1 0", d, l, e);
        end
        total++;
        if (we_addr_q.size() - q0 != 8) begin
            bad++;
            $display("FAIL fill_we_count got=%0d want=8", we_addr_q.size() - q0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (we_addr_q[q0 + i] !== 4'(i) || we_cyc_q[q0 + i] != we_cyc_q[q0] + i) begin
                    bad++;
                    $display("FAIL fill_we%0d got a=%h dc=%0d want a=%h dc=%0d", i, we_addr_q[q0 + i], we_cyc_q[q0 + i] - we_cyc_q[q0], 4'(i), i);
                end
            end
        end
        run_dump(1'b0);
    endtask

    task automatic test_random_rw();
        logic [3:0] d, a, v;
        logic       l, e;
        for (int k = 0; k < 12; k++) begin
            a = 4'($urandom_range(0, 9));
            v = 4'($urandom_range(0, 15));
            do_cmd(2'd0, a, v);
            get_beat(1'b0, d, l, e);
            if (a < 4'd8) ref_mem[a[2:0]] = v;
            a = 4'($urandom_range(0, 9));
            do_cmd(2'd1, a, 4'h0);
            get_beat(1'b0, d, l, e);
            total++;
            if (d !== ((a < 4'd8) ? ref_mem[a[2:0]] : 4'h0) || e !== (a >= 4'd8) || l !== 1'b1) begin
                bad++;
                $display("FAIL rand_read%0d a=%h got d=%h e=%b l=%b want d=%h e=%b l=1", k, a, d, e, l,
                         (a < 4'd8) ? ref_mem[a[2:0]] : 4'h0, a >= 4'd8);
            end
        end
    endtask

    task automatic test_dump_random_ready();
        run_dump(1'b1);
        run_dump(1'b1);
    endtask

    task automatic test_reset_mid_fill();
        logic [3:0] d;
        logic       l, e;
        int         n = 0;
        do_cmd(2'd2, 4'h0, 4'h3);
        get_beat(1'b0, d, l, e);
        for (int i = 0; i < 8; i++) ref_mem[i] = 4'h3;
        do_cmd(2'd2, 4'h0, 4'hC);
        while (!(bif.mem_we === 1'b1 && bif.mem_addr === 4'h4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL fill_reach_addr4 got=timeout want=we_at_4");
        end
        rst = 1'b1;
        #1;
        total++;
        if (bif.mem_we !== 1'b0 || bif.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got we=%b busy=%b want 0 0", bif.mem_we, bif.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'hC;
        repeat (3) @(negedge clk);
        check_idle("post_rst");
        run_dump(1'b0);
    endtask

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 2'd0;
        bif.cmd_addr  = 4'h0;
        bif.cmd_data  = 4'h0;
        bif.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_write_oob();
        test_fill_dump();
        test_random_rw();
        test_dump_random_ready();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
